// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory sequencer: default widths, the FSM
// state encoding and a small helper used by the controller.
package mem_ctrl_pkg;

    // Default address and RAM data widths.
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    // Controller states: manual stepping, auto-run, single-cycle write.
    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_RUN    = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    // Return-to state after a write, chosen by the run switch level.
    function automatic state_t idle_state(input logic run_sw);
        return run_sw ? ST_RUN : ST_MANUAL;
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_tick_gen.sv
// Auto-step tick divider. Counts enabled cycles and emits a one-cycle tick
// on every TICK_DIV-th enabled cycle. clr restarts the count from zero;
// when neither en nor clr is set the count holds.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick fires in the last enabled cycle of each period.
    assign tick = en && (cnt_q == CNT_LAST);

    // Next count: clear, wrap at the end of a period, count, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Memory address sequencer. Walks a RAM address either on manual step
// pulses or on divider ticks in run mode, and inserts single-cycle writes
// on request. Writes take priority over stepping; a step or tick that
// coincides with a write request, or arrives during the write cycle, is
// dropped. rd_valid marks the cycle in which a synchronous-read RAM has
// fresh data after an address change or a completed write.
module mem_seq_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_sw,
    input  logic              step,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] ram_din,
    output logic              rd_valid,
    output logic              wrap,
    output logic              busy,
    output state_t            state_dbg
);

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] ram_din_q,  ram_din_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wrap_q,     wrap_d;
    // High in the cycle right after addr advanced.
    logic              adv_q,      adv_d;

    logic              adv_req;
    logic              tick;
    logic              div_en;
    logic              div_clr;

    // Divider runs only in RUN, is held at zero in MANUAL, holds in WRITE.
    assign div_en  = (state_q == ST_RUN);
    assign div_clr = (state_q == ST_MANUAL);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (div_en),
        .clr   (div_clr),
        .tick  (tick)
    );

    // Next-state, address advance and output register inputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        ram_din_d  = ram_din_q;
        adv_d      = 1'b0;
        wrap_d     = 1'b0;
        rd_valid_d = adv_q | we_q;
        adv_req    = 1'b0;

        case (state_q)
            ST_MANUAL: begin
                if (wr_req) begin
                    state_d   = ST_WRITE;
                    we_d      = 1'b1;
                    ram_din_d = wr_data;
                end else begin
                    adv_req = step;
                    state_d = idle_state(run_sw);
                end
            end
            ST_RUN: begin
                if (wr_req) begin
                    state_d   = ST_WRITE;
                    we_d      = 1'b1;
                    ram_din_d = wr_data;
                end else begin
                    adv_req = tick;
                    state_d = idle_state(run_sw);
                end
            end
            ST_WRITE: begin
                state_d = idle_state(run_sw);
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase

        if (adv_req) begin
            addr_d = addr_q + ADDR_W'(1);
            adv_d  = 1'b1;
            wrap_d = &addr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_MANUAL;
            addr_q     <= '0;
            we_q       <= 1'b0;
            ram_din_q  <= '0;
            rd_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
            adv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            ram_din_q  <= ram_din_d;
            rd_valid_q <= rd_valid_d;
            wrap_q     <= wrap_d;
            adv_q      <= adv_d;
        end
    end

    assign addr      = addr_q;
    assign we        = we_q;
    assign ram_din   = ram_din_q;
    assign rd_valid  = rd_valid_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q == ST_WRITE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl with a small divider. Every clock edge updates a
// behavioural model and every output is compared just after the edge.
module tb_mem_seq_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int TICK_DIV = 4;
    localparam int ADDR_N   = 1 << ADDR_W;

    localparam int M_MAN = 0;
    localparam int M_RUN = 1;
    localparam int M_WR  = 2;

    logic              clk;
    logic              reset;
    logic              run_sw;
    logic              step;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] ram_din;
    logic              rd_valid;
    logic              wrap;
    logic              busy;
    state_t            state_dbg;

    int checks;
    int failures;

    // Behavioural model
    int m_addr;
    int m_din;
    int m_we;
    int m_rdv;
    int m_wrap;
    int m_mode;
    int m_run_cycles;
    int m_event;

    mem_seq_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_sw    (run_sw),
        .step      (step),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .addr      (addr),
        .we        (we),
        .ram_din   (ram_din),
        .rd_valid  (rd_valid),
        .wrap      (wrap),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic state_t mode_state(input int m);
        if (m == M_RUN) return ST_RUN;
        if (m == M_WR) return ST_WRITE;
        return ST_MANUAL;
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_step();
        int  old_mode;
        bit  adv;
        bit  tick_now;
        if (reset) begin
            m_addr = 0; m_din = 0; m_we = 0; m_rdv = 0; m_wrap = 0;
            m_mode = M_MAN; m_run_cycles = 0; m_event = 0;
        end else begin
            old_mode = m_mode;
            adv      = 1'b0;
            m_rdv    = m_event;
            m_we     = 0;
            m_wrap   = 0;
            // A tick lands on every TICK_DIV-th cycle spent in RUN.
            tick_now = (old_mode == M_RUN) && (((m_run_cycles + 1) % TICK_DIV) == 0);
            if (old_mode == M_RUN) m_run_cycles++;
            else if (old_mode == M_MAN) m_run_cycles = 0;
            if (old_mode == M_WR) begin
                m_mode = run_sw ? M_RUN : M_MAN;
            end else if (wr_req) begin
                m_we   = 1;
                m_din  = int'(wr_data);
                m_mode = M_WR;
            end else begin
                adv    = (old_mode == M_MAN) ? step : tick_now;
                m_mode = run_sw ? M_RUN : M_MAN;
            end
            if (adv) begin
                m_wrap = (m_addr == ADDR_N - 1) ? 1 : 0;
                m_addr = (m_addr + 1) % ADDR_N;
            end
            m_event = (adv || m_we) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        chk("addr",     32'(addr),      32'(m_addr));
        chk("we",       32'(we),        32'(m_we));
        chk("ram_din",  32'(ram_din),   32'(m_din));
        chk("rd_valid", 32'(rd_valid),  32'(m_rdv));
        chk("wrap",     32'(wrap),      32'(m_wrap));
        chk("busy",     32'(busy),      32'((m_mode == M_WR) ? 1 : 0));
        chk("state",    32'(state_dbg), 32'(mode_state(m_mode)));
    endtask

    // Apply inputs for one cycle, then compare just after the edge.
    task automatic cyc(input logic r, input logic rs, input logic st,
                       input logic wq, input logic [DATA_W-1:0] wd);
        reset   = r;
        run_sw  = rs;
        step    = st;
        wr_req  = wq;
        wr_data = wd;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a0;
        int n;
        bit r_run;
        checks   = 0;
        failures = 0;
        reset = 1'b1; run_sw = 1'b0; step = 1'b0; wr_req = 1'b0; wr_data = '0;

        // Reset values
        do_reset();
        chk("rst_addr",  32'(addr),      32'(0));
        chk("rst_state", 32'(state_dbg), 32'(ST_MANUAL));

        // Three manual steps with idle gaps
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
            chk("step_addr", 32'(addr), 32'(i));
            cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("step_rdv", 32'(rd_valid), 32'(1));
        end

        // Preload 254 and auto-run through the wrap
        do_reset();
        steps(254);
        chk("preload", 32'(addr), 32'(254));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
            if (i < 4) chk("run_hold", 32'(addr), 32'(254));
            if (i == 4) begin
                chk("run_255", 32'(addr), 32'(255));
                chk("run_nowrap", 32'(wrap), 32'(0));
            end
            if (i == 8) begin
                chk("run_0", 32'(addr), 32'(0));
                chk("run_wrap", 32'(wrap), 32'(1));
            end
        end

        // Write at addr 7
        do_reset();
        steps(7);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        chk("wr_we",   32'(we),      32'(1));
        chk("wr_addr", 32'(addr),    32'(7));
        chk("wr_din",  32'(ram_din), 32'(16'hBEEF));
        chk("wr_busy", 32'(busy),    32'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("wr_after_addr", 32'(addr), 32'(7));
        chk("wr_after_we",   32'(we),   32'(0));

        // Step coinciding with write is dropped
        do_reset();
        steps(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        chk("coll_we",   32'(we),   32'(1));
        chk("coll_addr", 32'(addr), 32'(3));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("coll_wr_step", 32'(addr), 32'(3));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("coll_done", 32'(addr), 32'(3));

        // Reset during the write cycle
        steps(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
        chk("rw_we", 32'(we), 32'(1));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rw_we_off", 32'(we),        32'(0));
        chk("rw_addr",   32'(addr),      32'(0));
        chk("rw_state",  32'(state_dbg), 32'(ST_MANUAL));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rw_no_rdv", 32'(rd_valid),  32'(0));

        // Run switch toggle restarts the divider
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        a0 = addr;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
            n++;
            if (addr != a0) break;
        end
        chk("toggle_latency", 32'(n), 32'(TICK_DIV));

        // Randomised traffic
        do_reset();
        r_run = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) r_run = ~r_run;
            cyc(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                r_run,
                ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                DATA_W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the RAM data width.
REQ-003 Parameter TICK_DIV, default 50_000_000, SHALL set the clk cycles per auto-step tick; the minimum legal value is 2.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 run_sw  in  1  SHALL be a level input: 1 = auto-run mode, 0 = manual mode.
REQ-007 step  in  1  SHALL be a one-cycle pulse requesting a manual address advance.
REQ-008 wr_req  in  1  SHALL be a one-cycle pulse requesting a write of wr_data at the current address.
REQ-009 wr_data  in  DATA_W  SHALL be the write data, sampled in the cycle wr_req=1.
REQ-010 addr  out  ADDR_W  SHALL be the registered RAM address.
REQ-011 we  out  1  SHALL be the registered RAM write enable.
REQ-012 ram_din  out  DATA_W  SHALL be the registered RAM write data.
REQ-013 rd_valid  out  1  SHALL pulse high for one cycle, one cycle after every addr change or write completion (synchronous-read RAM latency).
REQ-014 wrap  out  1  SHALL pulse high for one cycle in the cycle addr transitions from 2^ADDR_W-1 to 0.
REQ-015 busy  out  1  SHALL be high exactly while the FSM is in the WRITE state.

Function
REQ-016 The FSM SHALL have exactly three states: MANUAL, RUN and WRITE.
REQ-017 MANUAL SHALL transition to RUN when run_sw=1, and RUN SHALL transition to MANUAL when run_sw=0, both with one cycle of latency.
REQ-018 In MANUAL, step=1 SHALL increment addr by 1 on the next edge.
REQ-019 In RUN, each internal tick SHALL increment addr by 1, and step SHALL be ignored.
REQ-020 Increment SHALL be modulo 2^ADDR_W, so 255 SHALL go to 0 with wrap=1 in the same cycle.
REQ-021 wr_req=1 in MANUAL or RUN SHALL enter WRITE, capture wr_data into ram_din, and assert we for exactly one cycle at the unchanged addr.
REQ-022 WRITE SHALL last exactly one cycle, then go to RUN if run_sw=1, else MANUAL.
REQ-023 Priority SHALL be reset > wr_req > tick/step; any step or tick coinciding with wr_req, or arriving while in WRITE, SHALL be dropped (not queued).
REQ-024 wr_req arriving while in WRITE SHALL be ignored.
REQ-025 The tick divider SHALL count only in RUN, SHALL restart from 0 on entry to RUN, and SHALL hold during WRITE.
REQ-026 The tick divider SHALL produce a tick every TICK_DIV cycles of continuous RUN, with the first tick TICK_DIV cycles after RUN entry.
REQ-027 addr SHALL never change in the cycle we=1.

Reset
REQ-028 While reset=1, the outputs SHALL be: addr=0, we=0, ram_din=0, rd_valid=0, wrap=0, busy=0.
REQ-029 While reset=1, the FSM SHALL be in MANUAL and the tick divider SHALL be at 0.
REQ-030 Reset asserted during WRITE SHALL suppress we in the following cycle and SHALL discard the pending write.
REQ-031 rd_valid SHALL NOT pulse on the first cycle after reset release.

Structure
REQ-032 The state encoding constants and the default ADDR_W and DATA_W SHALL reside in the shared package mem_ctrl_pkg.
REQ-033 The tick divider SHALL be a sub-module tick_gen (ports clk, reset, en, clr, tick) parameterised by TICK_DIV.
REQ-034 The mem_seq_ctrl top SHALL contain the FSM, the address register and the output registers.

Verification (TICK_DIV=4)
REQ-035 Reset, then 3 step pulses in MANUAL -> addr 0->1->2->3; each change SHALL be followed one cycle later by a rd_valid pulse.
REQ-036 Preload addr=254, run_sw=1 -> addr SHALL become 255 then 0 at 4-cycle intervals, with wrap=1 only on the 255->0 edge.
REQ-037 At addr=7, wr_req with wr_data=16'hBEEF -> we=1 for one cycle with addr=7 and ram_din=BEEF; busy=1 in that same cycle; addr SHALL remain 7.
REQ-038 Drive step and wr_req in the same cycle at addr=3 -> the write SHALL occur at addr 3 and addr SHALL remain 3 (the step is dropped).
REQ-039 Assert reset in the WRITE cycle -> we=0 next cycle, addr=0, and the FSM SHALL be in MANUAL.
REQ-040 Toggle run_sw 1->0->1 mid-count -> no tick SHALL occur until 4 cycles after RUN re-entry.
